// File: rtl/jk_pkg.sv
// Shared encodings for the JK bank arbiter: command ops (J,K bit order) and FSM states.
package jk_pkg;

    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_CLEAR  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    typedef enum logic {
        ST_IDLE,
        ST_APPLY
    } state_t;

endpackage

// File: rtl/jk_bank_arbiter_if.sv
// Requester-side bundle of the JK bank arbiter: per-requester commands in, grant and bank state out.
interface jk_bank_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int NBITS = 8
) ();
    localparam int IW = $clog2(NBITS);

    logic [NREQ-1:0]    req;
    logic [2*NREQ-1:0]  cmd_op;
    logic [IW*NREQ-1:0] cmd_idx;
    logic [NREQ-1:0]    gnt;
    logic [NBITS-1:0]   q;
    logic               busy;
    logic               err;

    modport master (
        output req, cmd_op, cmd_idx,
        input  gnt, q, busy, err
    );

    modport slave (
        input  req, cmd_op, cmd_idx,
        output gnt, q, busy, err
    );

endinterface

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous active-high reset; J=K=1 toggles.
module jk_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                JK_HOLD:   q <= q;
                JK_CLEAR:  q <= 1'b0;
                JK_SET:    q <= 1'b1;
                JK_TOGGLE: q <= ~q;
                default:   q <= q;
            endcase
        end
    end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter serialising one JK command at a time from NREQ requesters onto a bank
// of NBITS JK cells; each granted command occupies one IDLE cycle and one APPLY cycle.
module jk_bank_arbiter
    import jk_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int NBITS = 8
) (
    input logic              clk,
    input logic              reset,
    jk_bank_arbiter_if.slave bus
);

    localparam int IW = $clog2(NBITS);
    localparam int PW = $clog2(NREQ);

    state_t          state_q, state_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [1:0]      op_q, op_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;

    logic            win_valid;
    logic [PW-1:0]   win;
    logic [PW-1:0]   cand;
    logic [1:0]      win_op;
    logic [IW-1:0]   win_idx;

    logic [NBITS-1:0] j_vec, k_vec, q_vec;

    // Search starts at rr_ptr and wraps, so the previous winner has lowest priority.
    always_comb begin
        win_valid = 1'b0;
        win       = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = PW'((int'(rr_ptr_q) + k) % NREQ);
            if (!win_valid && bus.req[cand]) begin
                win_valid = 1'b1;
                win       = cand;
            end
        end
        win_op  = bus.cmd_op[2*int'(win) +: 2];
        win_idx = bus.cmd_idx[IW*int'(win) +: IW];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (win_valid) state_d = ST_APPLY;
            ST_APPLY: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        op_d     = op_q;
        idx_d    = idx_q;
        gnt_d    = '0;
        busy_d   = 1'b0;
        err_d    = 1'b0;
        if (state_q == ST_IDLE && win_valid) begin
            rr_ptr_d   = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
            op_d       = win_op;
            idx_d      = win_idx;
            gnt_d[win] = 1'b1;
            busy_d     = 1'b1;
            err_d      = int'(win_idx) >= NBITS;
        end
    end

    // Only the latched target sees J/K; an out-of-range index matches no cell.
    always_comb begin
        j_vec = '0;
        k_vec = '0;
        if (state_q == ST_APPLY) begin
            for (int b = 0; b < NBITS; b++) begin
                if (idx_q == IW'(b)) begin
                    j_vec[b] = op_q[1];
                    k_vec[b] = op_q[0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= '0;
            op_q     <= JK_HOLD;
            idx_q    <= '0;
            gnt_q    <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            op_q     <= op_d;
            idx_q    <= idx_d;
            gnt_q    <= gnt_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    for (genvar b = 0; b < NBITS; b++) begin : g_cell
        jk_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .j     (j_vec[b]),
            .k     (k_vec[b]),
            .q     (q_vec[b])
        );
    end

    assign bus.gnt  = gnt_q;
    assign bus.busy = busy_q;
    assign bus.err  = err_q;
    assign bus.q    = q_vec;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter: an 8-cell bank for the main scenarios and a 6-cell bank
// where 3-bit indices 6 and 7 are out of range.
module tb_jk_bank_arbiter;
    import jk_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    jk_bank_arbiter_if #(.NREQ(4), .NBITS(8)) b8 ();
    jk_bank_arbiter_if #(.NREQ(4), .NBITS(6)) b6 ();

    jk_bank_arbiter #(.NREQ(4), .NBITS(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (b8)
    );

    jk_bank_arbiter #(.NREQ(4), .NBITS(6)) dut6 (
        .clk   (clk),
        .reset (reset),
        .bus   (b6)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd8(input int r, input logic [1:0] op, input logic [2:0] idx);
        b8.cmd_op[2*r +: 2]  = op;
        b8.cmd_idx[3*r +: 3] = idx;
    endtask

    task automatic set_cmd6(input int r, input logic [1:0] op, input logic [2:0] idx);
        b6.cmd_op[2*r +: 2]  = op;
        b6.cmd_idx[3*r +: 3] = idx;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        b8.req     = '0;
        b8.cmd_op  = '0;
        b8.cmd_idx = '0;
        b6.req     = '0;
        b6.cmd_op  = '0;
        b6.cmd_idx = '0;
        tick();
        tick();
        checks++;
        if ({b8.gnt, b8.busy, b8.err, b8.q} !== 15'h0) begin
            errors++;
            $display("FAIL reset_hold: got %h expected %h", {b8.gnt, b8.busy, b8.err, b8.q}, 15'h0);
        end
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if ({b8.gnt, b8.busy, b8.err, b8.q} !== 15'h0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: got %h expected %h", c,
                         {b8.gnt, b8.busy, b8.err, b8.q}, 15'h0);
            end
        end
    endtask

    // Requester 2 alone: set, toggle, toggle on cell 5.
    task automatic test_single();
        logic [1:0] ops [3];
        logic [7:0] qs  [4];
        ops = '{JK_SET, JK_TOGGLE, JK_TOGGLE};
        qs  = '{8'h00, 8'h20, 8'h00, 8'h20};
        for (int v = 0; v < 3; v++) begin
            set_cmd8(2, ops[v], 3'd5);
            b8.req = 4'b0100;
            tick();
            checks++;
            if ({b8.gnt, b8.busy, b8.err, b8.q} !== {4'b0100, 1'b1, 1'b0, qs[v]}) begin
                errors++;
                $display("FAIL single_grant v%0d: got %h expected %h", v,
                         {b8.gnt, b8.busy, b8.err, b8.q}, {4'b0100, 1'b1, 1'b0, qs[v]});
            end
            b8.req = 4'b0000;
            tick();
            checks++;
            if ({b8.gnt, b8.busy, b8.err, b8.q} !== {4'b0000, 1'b0, 1'b0, qs[v+1]}) begin
                errors++;
                $display("FAIL single_update v%0d: got %h expected %h", v,
                         {b8.gnt, b8.busy, b8.err, b8.q}, {4'b0000, 1'b0, 1'b0, qs[v+1]});
            end
        end
    endtask

    // All four held, requester r sets cell r: grants 0,1,2,3 then 0 again after 8 cycles.
    task automatic test_fairness();
        logic [7:0]  q_exp;
        logic [3:0]  g_exp;
        logic [13:0] exp_v;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int r = 0; r < 4; r++) set_cmd8(r, JK_SET, 3'(r));
        b8.req = 4'b1111;
        q_exp  = 8'h00;
        for (int t = 1; t <= 9; t++) begin
            tick();
            if (t % 2 == 1) begin
                g_exp = 4'(1 << (((t - 1) / 2) % 4));
                exp_v = {g_exp, 1'b1, 1'b0, q_exp};
            end else begin
                q_exp = q_exp | 8'(1 << (t / 2 - 1));
                exp_v = {4'b0000, 1'b0, 1'b0, q_exp};
            end
            checks++;
            if ({b8.gnt, b8.busy, b8.err, b8.q} !== exp_v) begin
                errors++;
                $display("FAIL fairness t%0d: got %h expected %h", t,
                         {b8.gnt, b8.busy, b8.err, b8.q}, exp_v);
            end
        end
        b8.req = 4'b0000;
        tick();
        checks++;
        if ({b8.gnt, b8.busy, b8.q} !== {4'b0000, 1'b0, 8'h0F}) begin
            errors++;
            $display("FAIL fairness_final: got %h expected %h", {b8.gnt, b8.busy, b8.q},
                     {4'b0000, 1'b0, 8'h0F});
        end
    endtask

    // Pointer sits at 1; a hold by requester 1 moves it to 2, then 3 must beat 0.
    task automatic test_rr_ptr();
        set_cmd8(1, JK_HOLD, 3'd0);
        b8.req = 4'b0010;
        tick();
        checks++;
        if ({b8.gnt, b8.busy, b8.q} !== {4'b0010, 1'b1, 8'h0F}) begin
            errors++;
            $display("FAIL rr_hold_grant: got %h expected %h", {b8.gnt, b8.busy, b8.q},
                     {4'b0010, 1'b1, 8'h0F});
        end
        b8.req = 4'b0000;
        tick();
        checks++;
        if ({b8.gnt, b8.q} !== {4'b0000, 8'h0F}) begin
            errors++;
            $display("FAIL rr_hold_q: got %h expected %h", {b8.gnt, b8.q}, {4'b0000, 8'h0F});
        end
        set_cmd8(0, JK_CLEAR, 3'd0);
        set_cmd8(3, JK_CLEAR, 3'd3);
        b8.req = 4'b1001;
        tick();
        checks++;
        if ({b8.gnt, b8.q} !== {4'b1000, 8'h0F}) begin
            errors++;
            $display("FAIL rr_first_3: got %h expected %h", {b8.gnt, b8.q}, {4'b1000, 8'h0F});
        end
        b8.req = 4'b0001;
        tick();
        checks++;
        if ({b8.gnt, b8.q} !== {4'b0000, 8'h07}) begin
            errors++;
            $display("FAIL rr_apply_3: got %h expected %h", {b8.gnt, b8.q}, {4'b0000, 8'h07});
        end
        tick();
        checks++;
        if ({b8.gnt, b8.q} !== {4'b0001, 8'h07}) begin
            errors++;
            $display("FAIL rr_then_0: got %h expected %h", {b8.gnt, b8.q}, {4'b0001, 8'h07});
        end
        b8.req = 4'b0000;
        tick();
        checks++;
        if ({b8.gnt, b8.q} !== {4'b0000, 8'h06}) begin
            errors++;
            $display("FAIL rr_apply_0: got %h expected %h", {b8.gnt, b8.q}, {4'b0000, 8'h06});
        end
    endtask

    // 6-cell bank: set cell 5, then clears aimed at idx 6 and 7 must flag err and leave q alone.
    task automatic test_err();
        logic [2:0] idxs [3];
        logic [1:0] ops  [3];
        logic       errs [3];
        logic [5:0] qs   [4];
        idxs = '{3'd5, 3'd6, 3'd7};
        ops  = '{JK_SET, JK_CLEAR, JK_CLEAR};
        errs = '{1'b0, 1'b1, 1'b1};
        qs   = '{6'h00, 6'h20, 6'h20, 6'h20};
        for (int v = 0; v < 3; v++) begin
            set_cmd6(1, ops[v], idxs[v]);
            b6.req = 4'b0010;
            tick();
            checks++;
            if ({b6.gnt, b6.busy, b6.err, b6.q} !== {4'b0010, 1'b1, errs[v], qs[v]}) begin
                errors++;
                $display("FAIL err_grant v%0d: got %h expected %h", v,
                         {b6.gnt, b6.busy, b6.err, b6.q}, {4'b0010, 1'b1, errs[v], qs[v]});
            end
            b6.req = 4'b0000;
            tick();
            checks++;
            if ({b6.gnt, b6.busy, b6.err, b6.q} !== {4'b0000, 1'b0, 1'b0, qs[v+1]}) begin
                errors++;
                $display("FAIL err_after v%0d: got %h expected %h", v,
                         {b6.gnt, b6.busy, b6.err, b6.q}, {4'b0000, 1'b0, 1'b0, qs[v+1]});
            end
        end
    endtask

    task automatic test_reset_apply();
        set_cmd8(1, JK_SET, 3'd7);
        b8.req = 4'b0010;
        tick();
        checks++;
        if ({b8.gnt, b8.busy, b8.q} !== {4'b0010, 1'b1, 8'h06}) begin
            errors++;
            $display("FAIL rst_apply_grant: got %h expected %h", {b8.gnt, b8.busy, b8.q},
                     {4'b0010, 1'b1, 8'h06});
        end
        reset  = 1'b1;
        b8.req = 4'b0000;
        tick();
        checks++;
        if ({b8.gnt, b8.busy, b8.err, b8.q} !== 15'h0) begin
            errors++;
            $display("FAIL rst_apply_abort: got %h expected %h", {b8.gnt, b8.busy, b8.err, b8.q},
                     15'h0);
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({b8.gnt, b8.busy, b8.q} !== 13'h0) begin
            errors++;
            $display("FAIL rst_apply_idle: got %h expected %h", {b8.gnt, b8.busy, b8.q}, 13'h0);
        end
        set_cmd8(2, JK_SET, 3'd1);
        b8.req = 4'b0100;
        tick();
        checks++;
        if ({b8.gnt, b8.busy, b8.q} !== {4'b0100, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL rst_apply_regrant: got %h expected %h", {b8.gnt, b8.busy, b8.q},
                     {4'b0100, 1'b1, 8'h00});
        end
        b8.req = 4'b0000;
        tick();
        checks++;
        if ({b8.gnt, b8.busy, b8.q} !== {4'b0000, 1'b0, 8'h02}) begin
            errors++;
            $display("FAIL rst_apply_update: got %h expected %h", {b8.gnt, b8.busy, b8.q},
                     {4'b0000, 1'b0, 8'h02});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_rr_ptr();
        test_err();
        test_reset_apply();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
